// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and constants for the serdes transmit/receive blocks.
//   state_t      - serializer FSM states
//   tx_entry_t   - FIFO entry {last, data}
//   BYTE_W       - serial byte width
//   BIT_CNT_W    - bit index width within a byte
//   PREAMBLE_DEFAULT - default frame preamble byte
package serdes_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] PREAMBLE_DEFAULT = 8'hD5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_entry_t;

endpackage

// File: rtl/serdes_sync_fifo.sv
// serdes_sync_fifo: single-clock FIFO, show-ahead read (rdata is the head entry).
//   clk, rst      - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   - write request / data; accepted when not full, or when full
//                   together with a pop (the pop frees the slot)
//   pop           - remove head entry; ignored when empty
//   rdata         - current head entry (undefined when empty)
//   full, empty   - status flags
module serdes_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en, rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/serdes_tx_serializer.sv
// serdes_tx_serializer: byte-to-serial transmitter with input FIFO and preamble.
//   clk, rst          - clock, asynchronous active-high reset
//   en                - transmit enable; low freezes shifter/state, drops ser_valid
//   s_data/s_last/s_valid/s_ready - byte input handshake (s_last ends a frame)
//   ser_out           - registered serial bit, LSB first, 8 clocks per byte
//   ser_valid         - ser_out carries a real bit this cycle
//   busy              - FSM active or FIFO holds data
//   underrun          - one-cycle pulse when the FIFO runs dry inside a frame
//   frame_cnt         - completed frames, wrapping
module serdes_tx_serializer
    import serdes_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [BYTE_W-1:0] PREAMBLE    = PREAMBLE_DEFAULT,
    parameter bit                PREAMBLE_EN = 1'b1,
    parameter logic              IDLE_LEVEL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              underrun,
    output logic [7:0]        frame_cnt
);

    tx_entry_t             wr_entry, head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    state_t                state;
    logic [BYTE_W-1:0]     shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  cur_last;   // byte in shreg closes the frame
    logic                  starved;    // in DATA, waiting for a byte after underrun
    logic                  last_bit;

    assign s_ready  = !fifo_full && !rst;
    assign push     = s_valid && s_ready;
    assign wr_entry = {s_last, s_data};
    assign busy     = (state != IDLE) || !fifo_empty;
    assign last_bit = (bit_cnt == '1);

    serdes_sync_fifo #(
        .WIDTH ($bits(tx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop exactly when the FSM below loads head into the shifter.
    always_comb begin
        pop = 1'b0;
        if (en && !fifo_empty) begin
            case (state)
                IDLE:    pop = !PREAMBLE_EN;
                PRE:     pop = last_bit;
                DATA:    pop = starved || (last_bit && !cur_last);
                default: pop = 1'b0;
            endcase
        end
    end

    // shreg holds the byte being sent; ser_out registers shreg[0] so a byte
    // loaded at one edge shows bit 0 after the next edge. Loading the next
    // byte on the bit-7 edge keeps consecutive bytes back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cur_last  <= 1'b0;
            starved   <= 1'b0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (!en) begin
                ser_valid <= 1'b0;   // ser_out holds its last value
            end else begin
                case (state)
                    IDLE: begin
                        ser_valid <= 1'b0;
                        ser_out   <= IDLE_LEVEL;
                        if (!fifo_empty) begin
                            bit_cnt <= '0;
                            if (PREAMBLE_EN) begin
                                shreg    <= PREAMBLE;
                                cur_last <= 1'b0;
                                state    <= PRE;
                            end else begin
                                shreg    <= head.data;
                                cur_last <= head.last;
                                state    <= DATA;
                            end
                        end
                    end
                    PRE, DATA: begin
                        if (starved) begin
                            ser_valid <= 1'b0;
                            ser_out   <= IDLE_LEVEL;
                            if (!fifo_empty) begin
                                shreg    <= head.data;
                                cur_last <= head.last;
                                bit_cnt  <= '0;
                                starved  <= 1'b0;
                            end
                        end else begin
                            ser_valid <= 1'b1;
                            ser_out   <= shreg[0];
                            if (!last_bit) begin
                                shreg   <= shreg >> 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else if (state == DATA && cur_last) begin
                                frame_cnt <= frame_cnt + 8'd1;
                                state     <= GAP;
                            end else begin
                                // Byte boundary inside a frame: next byte or starve.
                                state   <= DATA;
                                bit_cnt <= '0;
                                if (!fifo_empty) begin
                                    shreg    <= head.data;
                                    cur_last <= head.last;
                                end else begin
                                    starved  <= 1'b1;
                                    underrun <= 1'b1;
                                end
                            end
                        end
                    end
                    GAP: begin
                        ser_valid <= 1'b0;
                        ser_out   <= IDLE_LEVEL;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/serdes_tx_serializer.md
Name: serdes_tx_serializer

Overview:
Upstream transmit stage for the serdes receiver. It accepts parallel bytes over a valid/ready interface, buffers them in a small FIFO, and prepends a preamble byte to each frame. Each byte is driven LSB first, one bit per clock, on a single serial line. Its output feeds the receiver's serial input pin directly, at the same bit timing the receiver expects: 8 consecutive clocks per byte.

Parameters:
DATA_W, 8, byte width; only 8 is supported.
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, minimum 2.
PREAMBLE, 8'hD5, byte sent before the first data byte of every frame.
PREAMBLE_EN, 1, 1 inserts the preamble; 0 sends data bytes only.
IDLE_LEVEL, 1'b0, ser_out level whenever no bit is being driven.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  transmit enable; 0 stalls the shifter
s_data  in  8  byte to send
s_valid  in  1  s_data/s_last valid
s_last  in  1  byte is the last one of its frame
s_ready  out  1  FIFO can accept a byte
ser_out  out  1  serial bit, registered
ser_valid  out  1  ser_out carries a real bit this cycle
busy  out  1  state is not IDLE or FIFO is not empty
underrun  out  1  one-cycle pulse on a mid-frame FIFO starvation
frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- Reset (asynchronous, rst=1):
  - FIFO is emptied; state goes to IDLE.
  - ser_out=IDLE_LEVEL; ser_valid=0; underrun=0; frame_cnt=0; s_ready=0 while rst is high.
  - Reset asserted mid-byte aborts the byte immediately. No partial-frame recovery.
- Input handshake:
  - Transfer occurs when s_valid & s_ready at a rising edge.
  - s_ready = !fifo_full, registered-free.
  - A push and a pop in the same cycle are both allowed when full: the pop frees the slot.
  - s_ready is independent of en.
- FIFO: entries are {s_last, s_data}. Binary pointers are one bit wider than the address, for full/empty detection.
- Shift register: 8 bits plus a 3-bit bit counter. ser_out = shreg[0], registered. Shifts right once per cycle while en=1.
- State machine (states IDLE, PRE, DATA, GAP):
  - IDLE: ser_valid=0, ser_out=IDLE_LEVEL.
    - If en & FIFO non-empty and PREAMBLE_EN=1: load PREAMBLE, go to PRE.
    - If en & FIFO non-empty and PREAMBLE_EN=0: pop the FIFO head, load it, go to DATA.
  - PRE: drives 8 preamble bits with ser_valid=1. After bit 7:
    - FIFO non-empty: pop and load, go to DATA with no gap cycle.
    - FIFO empty: underrun.
  - DATA: drives 8 bits with ser_valid=1. At bit 7:
    - Current byte had last=1: frame_cnt++, go to GAP.
    - Else, FIFO non-empty: pop and load back-to-back, giving the next bit 0 on the very next cycle.
    - Else: underrun.
  - GAP: exactly one cycle, ser_valid=0, ser_out=IDLE_LEVEL, then IDLE. This guarantees a frame delimiter.
  - Underrun (FIFO empty at a byte boundary inside a frame):
    - underrun pulses for 1 cycle.
    - ser_valid=0 and ser_out=IDLE_LEVEL until a byte arrives.
    - The next byte is then loaded and DATA resumes with no new preamble.
- en=0 effects:
  - Freezes the shifter, bit counter and state.
  - Forces ser_valid=0 while holding ser_out.
  - Resuming continues at the same bit.
  - en=0 in IDLE prevents any frame start.
- Latency: with IDLE, empty FIFO, PREAMBLE_EN=0 and en=1, a byte accepted at edge N (written into the FIFO at edge N) appears as bit 0 on ser_out during the cycle after edge N+2 (edge N+1 pops and loads, edge N+2 registers ser_out). With PREAMBLE_EN=1, bit 0 of data comes 8 cycles later.
- busy = (state != IDLE) | !fifo_empty.

Decomposition:
- Package serdes_pkg:
  - state enum: IDLE, PRE, DATA, GAP.
  - BYTE_W=8 and BIT_CNT_W=3.
  - default PREAMBLE constant 8'hD5.
- Sub-module serdes_sync_fifo: parameterised width/depth synchronous FIFO with full, empty and push/pop. It will be reused by the receive side.
- The FSM and shifter stay in the top module.

Test Plan:
- PREAMBLE_EN=0, push 8'hA5 with last=1 -> ser_valid high for 8 cycles; ser_out sequence 1,0,1,0,0,1,0,1; then 1 GAP cycle; frame_cnt=1.
- PREAMBLE_EN=1, push 8'h3C then 8'hC3 (last) back-to-back -> 24 contiguous valid bits: D5 LSB-first (1,0,1,0,1,0,1,1), then 3C, then C3; no gaps; frame_cnt=1.
- Push 6 bytes while en=0 -> s_ready drops after 4 accepts. Raise en -> all 4 bytes sent in order, and s_ready rises again once the first byte is popped.
- Push 8'h01 (last=0), then wait 20 cycles, then push 8'h80 (last=1) -> underrun pulses once after the first byte; ser_valid=0 during the wait; 8'h80 follows with no second preamble.
- Drop en for 3 cycles mid-byte on 8'hF0 -> ser_valid=0 for 3 cycles, ser_out held, and the remaining bits of F0 continue unchanged.
- Assert rst at bit 4 of a byte -> same cycle: ser_valid=0, ser_out=IDLE_LEVEL, s_ready=0. After release: FIFO empty, frame_cnt=0, IDLE.
